adc_i2c_arbiter: RTL and testbench

Shares one ADS122C04 I2C controller between two requesters:
- CPU single-register accesses (write, or register read).
- A periodic hardware conversion scan of AIN0..AIN3.

The block drives the controller's control word, register address and write data, and watches its status fields to find transaction and scan boundaries. It sits between the CPU register bank / scan timer and the I2C controller instance.

---
 rtl/adc_i2c_pkg.sv | 37 +++
 rtl/adc_i2c_status_sync.sv | 42 ++++
 rtl/adc_i2c_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_adc_i2c_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_i2c_pkg.sv
// Shared definitions for the ADS122C04 I2C controller arbiter: op codes,
// controller status field positions and the arbiter state encoding.
package adc_i2c_pkg;

    localparam logic [2:0] CPU_WREG = 3'd0;
    localparam logic [2:0] CPU_RREG = 3'd1;
    localparam logic [2:0] HW       = 3'd2;
    localparam logic [2:0] PARK     = 3'd7;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned FINISH_BIT  = 1;
    localparam int unsigned HW_SM_LSB   = 12;
    localparam int unsigned HW_SM_MSB   = 14;
    localparam int unsigned AIN_SEL_LSB = 15;
    localparam int unsigned AIN_SEL_MSB = 16;

    localparam int unsigned FLAG_W    = FINISH_BIT + 1;
    localparam int unsigned HW_SM_W   = HW_SM_MSB - HW_SM_LSB + 1;
    localparam int unsigned AIN_SEL_W = AIN_SEL_MSB - AIN_SEL_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ISSUE,
        ST_CPU_WAIT,
        ST_CPU_END,
        ST_HW_ISSUE,
        ST_HW_RUN,
        ST_HW_PARK
    } arb_state_e;

    // Controller control word: [0] enable, [3:1] op_mode, [6:4] rate.
    function automatic logic [31:0] ctrl_word(input logic en, input logic [2:0] op,
                                              input logic [2:0] rate);
        return {25'b0, rate, op, en};
    endfunction

endpackage

// File: rtl/adc_i2c_status_sync.sv
// Two-flop synchroniser for the controller status fields, with rise/fall
// detection of ready and finish taken from the synchronised copies.
module adc_i2c_status_sync
    import adc_i2c_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [FLAG_W-1:0]    i_flags,
    input  logic [HW_SM_W-1:0]   i_hw_sm,
    input  logic [AIN_SEL_W-1:0] i_ain_sel,
    output logic                 o_ready,
    output logic                 o_ready_fall_c,
    output logic                 o_finish_rise_c,
    output logic [HW_SM_W-1:0]   o_hw_sm,
    output logic [AIN_SEL_W-1:0] o_ain_sel
);

    localparam int unsigned SYNC_W = FLAG_W + HW_SM_W + AIN_SEL_W;

    logic [SYNC_W-1:0] meta;
    logic [SYNC_W-1:0] sync;
    logic [FLAG_W-1:0] prev_flags;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta       <= '0;
            sync       <= '0;
            prev_flags <= '0;
        end else begin
            meta       <= {i_ain_sel, i_hw_sm, i_flags};
            sync       <= meta;
            prev_flags <= sync[FLAG_W-1:0];
        end
    end

    assign o_ready         = sync[READY_BIT];
    assign o_ready_fall_c  = prev_flags[READY_BIT] & ~sync[READY_BIT];
    assign o_finish_rise_c = ~prev_flags[FINISH_BIT] & sync[FINISH_BIT];
    assign o_hw_sm         = sync[FLAG_W +: HW_SM_W];
    assign o_ain_sel       = sync[FLAG_W + HW_SM_W +: AIN_SEL_W];

endmodule

// File: rtl/adc_i2c_arbiter.sv
// Shares one ADS122C04 I2C controller between CPU register accesses and a
// periodic four-channel hardware conversion scan.
module adc_i2c_arbiter
    import adc_i2c_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD = 100_000,
    parameter int unsigned TIMEOUT     = 2_000_000,
    parameter logic [2:0]  CLK_RATE    = 3'd6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_scan_en,
    output logic        o_cpu_busy,
    output logic        o_cpu_done,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_scan_done,
    output logic [1:0]  o_err,
    output logic [31:0] o_ctl_ctrl,
    output logic [7:0]  o_ctl_reg_addr,
    output logic [7:0]  o_ctl_w_data,
    input  logic        i_ctl_ready,
    input  logic        i_ctl_finish,
    input  logic [2:0]  i_ctl_hw_sm,
    input  logic [1:0]  i_ctl_ain_sel,
    input  logic [7:0]  i_ctl_ain0
);

    localparam int unsigned SCAN_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] CTRL_PARK = ctrl_word(1'b0, PARK, CLK_RATE);

    logic [FLAG_W-1:0]    ctl_flags;
    logic                 ready_s;
    logic                 ready_fall;
    logic                 finish_rise;
    logic [HW_SM_W-1:0]   hw_sm_s;
    logic [AIN_SEL_W-1:0] ain_sel_s;

    arb_state_e        state;
    logic              cpu_rw;
    logic [7:0]        cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [2:0]        cpu_op;
    logic              scan_pend;
    logic              seen3;
    logic [SCAN_W-1:0] scan_cnt;
    logic [TO_W-1:0]   to_cnt;

    always_comb begin
        ctl_flags             = '0;
        ctl_flags[READY_BIT]  = i_ctl_ready;
        ctl_flags[FINISH_BIT] = i_ctl_finish;
    end

    adc_i2c_status_sync u_status_sync (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_flags         (ctl_flags),
        .i_hw_sm         (i_ctl_hw_sm),
        .i_ain_sel       (i_ctl_ain_sel),
        .o_ready         (ready_s),
        .o_ready_fall_c  (ready_fall),
        .o_finish_rise_c (finish_rise),
        .o_hw_sm         (hw_sm_s),
        .o_ain_sel       (ain_sel_s)
    );

    assign cpu_op = cpu_rw ? CPU_RREG : CPU_WREG;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            cpu_rw         <= 1'b0;
            cpu_addr       <= '0;
            cpu_wdata      <= '0;
            scan_pend      <= 1'b0;
            seen3          <= 1'b0;
            scan_cnt       <= '0;
            to_cnt         <= '0;
            o_cpu_busy     <= 1'b0;
            o_cpu_done     <= 1'b0;
            o_cpu_rdata    <= '0;
            o_scan_done    <= 1'b0;
            o_err          <= '0;
            o_ctl_ctrl     <= CTRL_PARK;
            o_ctl_reg_addr <= '0;
            o_ctl_w_data   <= '0;
        end else begin
            o_cpu_done  <= 1'b0;
            o_scan_done <= 1'b0;

            // One outstanding CPU request; extras are dropped and flagged
            if (i_cpu_req) begin
                if (!o_cpu_busy) begin
                    cpu_rw     <= i_cpu_rw;
                    cpu_addr   <= i_cpu_addr;
                    cpu_wdata  <= i_cpu_wdata;
                    o_cpu_busy <= 1'b1;
                end else begin
                    o_err[1] <= 1'b1;
                end
            end

            if (!i_scan_en) begin
                scan_cnt  <= '0;
                scan_pend <= 1'b0;
            end else if (scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
                scan_cnt  <= '0;
                scan_pend <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            if (state != ST_IDLE) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT - 1)) begin
                // Abort: park the controller and release whoever owned it
                o_ctl_ctrl <= CTRL_PARK;
                o_err[0]   <= 1'b1;
                seen3      <= 1'b0;
                state      <= ST_IDLE;
                if (state inside {ST_CPU_ISSUE, ST_CPU_WAIT, ST_CPU_END}) begin
                    o_cpu_busy  <= 1'b0;
                    o_cpu_done  <= 1'b1;
                    o_cpu_rdata <= 8'hFF;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ready_s && o_cpu_busy) begin
                            o_ctl_ctrl     <= ctrl_word(1'b1, cpu_op, CLK_RATE);
                            o_ctl_reg_addr <= cpu_addr;
                            o_ctl_w_data   <= cpu_wdata;
                            to_cnt         <= '0;
                            state          <= ST_CPU_ISSUE;
                        end else if (ready_s && scan_pend) begin
                            o_ctl_ctrl <= ctrl_word(1'b1, HW, CLK_RATE);
                            scan_pend  <= 1'b0;
                            to_cnt     <= '0;
                            state      <= ST_HW_ISSUE;
                        end
                    end
                    ST_CPU_ISSUE: begin
                        if (ready_fall) begin
                            o_ctl_ctrl <= ctrl_word(1'b0, cpu_op, CLK_RATE);
                            state      <= ST_CPU_WAIT;
                        end
                    end
                    // Ready pulses between read phases are ignored until finish
                    ST_CPU_WAIT: begin
                        if (finish_rise) begin
                            state <= ST_CPU_END;
                        end
                    end
                    ST_CPU_END: begin
                        if (ready_s) begin
                            if (cpu_rw) begin
                                o_cpu_rdata <= i_ctl_ain0;
                            end
                            o_cpu_done <= 1'b1;
                            o_cpu_busy <= 1'b0;
                            o_ctl_ctrl <= CTRL_PARK;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_HW_ISSUE: begin
                        if (ready_fall) begin
                            state <= ST_HW_RUN;
                        end
                    end
                    ST_HW_RUN: begin
                        if (ain_sel_s == AIN_SEL_W'(3)) begin
                            seen3 <= 1'b1;
                        end
                        if (seen3 && ain_sel_s == '0 && hw_sm_s == '0 && ready_s) begin
                            o_ctl_ctrl <= CTRL_PARK;
                            state      <= ST_HW_PARK;
                        end
                    end
                    ST_HW_PARK: begin
                        o_scan_done <= 1'b1;
                        seen3       <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_i2c_arbiter.sv
// Directed bench for adc_i2c_arbiter with a behavioural I2C controller model
// and a queue of expected CPU read-data results.
module tb_adc_i2c_arbiter;

    localparam int unsigned SCAN_P = 1000;
    localparam int unsigned TO_P   = 500;

    localparam logic [31:0] CTRL_PARK  = 32'h0000_006E;
    localparam logic [31:0] CTRL_HW    = 32'h0000_0065;
    localparam logic [31:0] CTRL_WR_EN = 32'h0000_0061;
    localparam logic [31:0] CTRL_WR    = 32'h0000_0060;
    localparam logic [31:0] CTRL_RD_EN = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_rw;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        scan_en;
    logic        cpu_busy;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic        scan_done;
    logic [1:0]  err;
    logic [31:0] ctl_ctrl;
    logic [7:0]  ctl_reg_addr;
    logic [7:0]  ctl_w_data;
    logic        ctl_ready;
    logic        ctl_finish;
    logic [2:0]  ctl_hw_sm;
    logic [1:0]  ctl_ain_sel;
    logic [7:0]  ctl_ain0;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_done   = 0;
    int          n_scan   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic        stuck    = 1'b0;
    logic [7:0]  rd_val   = 8'h3C;
    logic [2:0]  m_op;
    int          n;
    int          bad;

    always #5 clk = ~clk;

    adc_i2c_arbiter #(
        .SCAN_PERIOD (SCAN_P),
        .TIMEOUT     (TO_P),
        .CLK_RATE    (3'd6)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cpu_req      (cpu_req),
        .i_cpu_rw       (cpu_rw),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_wdata    (cpu_wdata),
        .i_scan_en      (scan_en),
        .o_cpu_busy     (cpu_busy),
        .o_cpu_done     (cpu_done),
        .o_cpu_rdata    (cpu_rdata),
        .o_scan_done    (scan_done),
        .o_err          (err),
        .o_ctl_ctrl     (ctl_ctrl),
        .o_ctl_reg_addr (ctl_reg_addr),
        .o_ctl_w_data   (ctl_w_data),
        .i_ctl_ready    (ctl_ready),
        .i_ctl_finish   (ctl_finish),
        .i_ctl_hw_sm    (ctl_hw_sm),
        .i_ctl_ain_sel  (ctl_ain_sel),
        .i_ctl_ain0     (ctl_ain0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_request(input logic rw, input logic [7:0] a, input logic [7:0] d);
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        tick();
        cpu_req   = 1'b0;
    endtask

    // Controller model: CPU ops drop ready, reads add an inter-phase ready
    // pulse, HW scans walk AIN0..AIN3 and return to ready/ain_sel 0/hw_sm 0.
    initial begin
        ctl_ready   = 1'b1;
        ctl_finish  = 1'b0;
        ctl_hw_sm   = '0;
        ctl_ain_sel = '0;
        ctl_ain0    = '0;
        forever begin
            tick();
            if (!stuck && ctl_ctrl[0]) begin
                m_op = ctl_ctrl[3:1];
                repeat (2) tick();
                ctl_ready  = 1'b0;
                ctl_finish = 1'b0;
                if (m_op == 3'd2) begin
                    for (int ch = 0; ch < 4; ch++) begin
                        ctl_ain_sel = 2'(ch);
                        ctl_hw_sm   = 3'd2;
                        repeat (6) tick();
                        ctl_hw_sm   = 3'd5;
                        repeat (2) tick();
                    end
                    ctl_ain_sel = '0;
                    ctl_hw_sm   = '0;
                    tick();
                    ctl_ready   = 1'b1;
                end else begin
                    repeat (5) tick();
                    if (m_op == 3'd1) begin
                        ctl_ready = 1'b1;
                        repeat (2) tick();
                        ctl_ready = 1'b0;
                        repeat (5) tick();
                        ctl_ain0  = rd_val;
                    end
                    ctl_finish = 1'b1;
                    repeat (2) tick();
                    ctl_ready  = 1'b1;
                end
                for (int k = 0; k < 1000 && ctl_ctrl[0]; k++) tick();
            end
        end
    end

    // Scoreboard side: every o_cpu_done pops one expected read-data value
    initial begin
        forever begin
            tick();
            if (cpu_done) begin
                n_done++;
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected_done observed=%0h expected=none", cpu_rdata);
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("sb_cpu_rdata", 32'(cpu_rdata), 32'(mon_exp));
                end
            end
            if (scan_done) n_scan++;
        end
    end

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        scan_en   = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", ctl_ctrl, CTRL_PARK);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_addr", 32'(ctl_reg_addr), 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // CPU write, scan disabled
        exp_q.push_back(8'h00);
        cpu_request(1'b0, 8'h44, 8'hA5);
        check("wr_busy", 32'(cpu_busy), 32'd1);
        n = 0;
        while (ctl_ctrl != CTRL_WR_EN && n < 50) begin tick(); n++; end
        check("wr_issue_ctrl", ctl_ctrl, CTRL_WR_EN);
        check("wr_reg_addr", 32'(ctl_reg_addr), 32'h44);
        check("wr_w_data", 32'(ctl_w_data), 32'hA5);
        n = 0;
        while (ctl_ctrl[0] && n < 100) begin tick(); n++; end
        check("wr_enable_drop", ctl_ctrl, CTRL_WR);
        n = 0;
        while (cpu_busy && n < 100) begin tick(); n++; end
        check("wr_busy_clear", 32'(cpu_busy), 32'd0);
        tick();
        check("wr_parked", ctl_ctrl, CTRL_PARK);
        check("wr_err", 32'(err), 32'd0);
        check("wr_done_count", 32'(n_done), 32'd1);

        // CPU read with an inter-phase ready pulse
        exp_q.push_back(8'h3C);
        cpu_request(1'b1, 8'h20, 8'h00);
        n = 0;
        while (ctl_ctrl != CTRL_RD_EN && n < 50) begin tick(); n++; end
        check("rd_issue_ctrl", ctl_ctrl, CTRL_RD_EN);
        check("rd_reg_addr", 32'(ctl_reg_addr), 32'h20);
        n = 0;
        while (cpu_busy && n < 100) begin tick(); n++; end
        repeat (5) tick();
        check("rd_rdata", 32'(cpu_rdata), 32'h3C);
        check("rd_done_count", 32'(n_done), 32'd2);

        // Periodic HW scan: op HW held for the scan, then parked
        scan_en = 1'b1;
        n = 0;
        while (ctl_ctrl != CTRL_HW && n < SCAN_P + 100) begin tick(); n++; end
        check("scan_issue_ctrl", ctl_ctrl, CTRL_HW);
        bad = 0;
        n = 0;
        while (!scan_done && n < 300) begin
            tick();
            n++;
            if (ctl_ctrl != CTRL_HW && ctl_ctrl != CTRL_PARK) bad++;
        end
        check("scan_op_held", 32'(bad), 32'd0);
        check("scan_parked", ctl_ctrl, CTRL_PARK);
        tick();
        check("scan_count1", 32'(n_scan), 32'd1);

        // CPU request mid-scan waits for the scan; a second request is dropped
        n = 0;
        while (!(ctl_ctrl == CTRL_HW && ctl_ain_sel == 2'd1) && n < SCAN_P + 100) begin tick(); n++; end
        check("mid_scan_running", ctl_ctrl, CTRL_HW);
        exp_q.push_back(8'h3C);
        cpu_rw    = 1'b0;
        cpu_addr  = 8'h10;
        cpu_wdata = 8'h5A;
        cpu_req   = 1'b1;
        tick();
        check("mid_busy", 32'(cpu_busy), 32'd1);
        tick();
        cpu_req = 1'b0;
        check("mid_drop_err", 32'(err), 32'd2);
        n = 0;
        while (!scan_done && n < 300) begin tick(); n++; end
        check("mid_busy_at_scan_done", 32'(cpu_busy), 32'd1);
        n = 0;
        while (ctl_ctrl != CTRL_WR_EN && n < 50) begin tick(); n++; end
        check("mid_issue_latency", 32'(n), 32'd1);
        check("mid_reg_addr", 32'(ctl_reg_addr), 32'h10);
        check("mid_w_data", 32'(ctl_w_data), 32'h5A);
        n = 0;
        while (cpu_busy && n < 100) begin tick(); n++; end
        check("mid_busy_clear", 32'(cpu_busy), 32'd0);
        scan_en = 1'b0;
        tick();
        check("mid_rdata_hold", 32'(cpu_rdata), 32'h3C);
        check("mid_scan_count", 32'(n_scan), 32'd2);

        // Controller never leaves ready: timeout abort
        stuck = 1'b1;
        repeat (3) tick();
        exp_q.push_back(8'hFF);
        cpu_request(1'b0, 8'h55, 8'h66);
        n = 0;
        while (ctl_ctrl != CTRL_WR_EN && n < 50) begin tick(); n++; end
        check("to_issue_ctrl", ctl_ctrl, CTRL_WR_EN);
        n = 0;
        while (ctl_ctrl[0] && n < TO_P + 100) begin tick(); n++; end
        check("to_cycles", 32'(n), 32'(TO_P));
        check("to_ctrl", ctl_ctrl, CTRL_PARK);
        check("to_err", 32'(err), 32'd3);
        check("to_done", 32'(cpu_done), 32'd1);
        check("to_busy", 32'(cpu_busy), 32'd0);
        tick();
        stuck = 1'b0;

        // Reset during HW_RUN, with a CPU request pending
        scan_en = 1'b1;
        n = 0;
        while (!(ctl_ctrl == CTRL_HW && ctl_ain_sel == 2'd2) && n < SCAN_P + 100) begin tick(); n++; end
        check("rst_run_ctrl", ctl_ctrl, CTRL_HW);
        cpu_request(1'b1, 8'h77, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_ctrl", ctl_ctrl, CTRL_PARK);
        check("rrst_busy", 32'(cpu_busy), 32'd0);
        check("rrst_err", 32'(err), 32'd0);
        check("rrst_rdata", 32'(cpu_rdata), 32'd0);
        n = 0;
        while (ctl_ctrl != CTRL_HW && n < SCAN_P + 100) begin tick(); n++; end
        check("rrst_timer_restart", 32'(n), 32'(SCAN_P + 1));
        n = 0;
        while (!scan_done && n < 300) begin tick(); n++; end
        tick();
        check("final_scan_count", 32'(n_scan), 32'd3);
        check("final_done_count", 32'(n_done), 32'd4);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
